// File: rtl/mem_dump_uart_pkg.sv
// Shared types and constants for the memory-dump serial streamer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_dump_uart_pkg;

  // Top-level sequencing states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    NEXT = 3'd4
  } state_t;

  // 8N1: start + 8 data + stop
  localparam int FRAME_BITS     = 10;
  // Each 16-bit RAM word leaves as two bytes, high byte first
  localparam int BYTES_PER_WORD = 2;

  // Clocks per serial bit, floored, never below 2 so the counter logic stays sane
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / baud;
    return (d < 2) ? 2 : d;
  endfunction

endpackage

// File: rtl/mem_dump_uart_tx_byte.sv
// 8N1 serial transmitter for a single byte, LSB first.
// Latency: Tx drops to the start bit on the edge that accepts Load; a frame is FRAME_BITS*DIV cycles.
// Backpressure: Idle high means Load is taken this cycle; it also rises in the last stop-bit cycle so frames chain with no gap.
module uart_tx_byte
  import mem_dump_uart_pkg::*;
#(
  parameter int DIV = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Load,
  input  logic [7:0] Data,
  output logic       Tx,
  output logic       Idle
);

  localparam int CNT_W = $clog2(DIV);
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  logic             active_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BIT_W-1:0] bit_q;
  logic [8:0]       shift_q;
  logic             tx_q;
  logic             last_cycle;

  // Final cycle of the stop bit: a new Load here starts the next start bit on the following edge
  assign last_cycle = active_q && (bit_q == BIT_LAST) && (cnt_q == CNT_LAST);
  assign Idle       = !active_q || last_cycle;
  assign Tx         = tx_q;

  // Baud counter, bit counter and shift register; Tx is registered so the line never glitches
  always_ff @(posedge Clk) begin
    if (Rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      tx_q     <= 1'b1;
    end else if (Load && Idle) begin
      // Start bit goes out immediately; the shift register holds data then the stop bit
      active_q <= 1'b1;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= {1'b1, Data};
      tx_q     <= 1'b0;
    end else if (active_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        if (bit_q == BIT_LAST) begin
          active_q <= 1'b0;
          tx_q     <= 1'b1;
        end else begin
          bit_q   <= bit_q + 1'b1;
          tx_q    <= shift_q[0];
          shift_q <= {1'b1, shift_q[8:1]};
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_dump_uart.sv
// Streams a block of RAM words out of port B as 8N1 bytes, high byte first.
// Latency: first start bit two cycles after the Start cycle; per-word period 20*DIV+3 cycles.
// Backpressure: none; Start is dropped while Busy or while Done is pulsing.
module mem_dump_uart
  import mem_dump_uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [ADDR_W:0]   Count,
  output logic [ADDR_W-1:0] RamAddrB,
  input  logic [DATA_W-1:0] RamQB,
  output logic              Tx,
  output logic              Busy,
  output logic              Done
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              byte_q, byte_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tx_load;
  logic [7:0]        tx_data;
  logic              tx_idle;

  assign RamAddrB = addr_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

  uart_tx_byte #(.DIV(DIV)) u_tx (
    .Clk  (Clk),
    .Rst  (Rst),
    .Load (tx_load),
    .Data (tx_data),
    .Tx   (Tx),
    .Idle (tx_idle)
  );

  // State and datapath registers; reset abandons any dump in progress
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      word_q  <= '0;
      byte_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath updates for the read/wait/send/next word loop
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    word_d  = word_q;
    byte_d  = byte_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tx_load = 1'b0;
    tx_data = word_q[7:0];

    case (state_q)
      IDLE: begin
        // Busy has already dropped while Done pulses, so that cycle is excluded explicitly
        if (Start && !done_q) begin
          if (Count != '0) begin
            addr_d  = BaseAddr;
            rem_d   = Count;
            busy_d  = 1'b1;
            state_d = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        state_d = WAIT;
      end
      WAIT: begin
        // RamQB is valid now; the high byte goes straight into the transmitter
        word_d  = RamQB;
        tx_load = 1'b1;
        tx_data = RamQB[DATA_W-1 -: 8];
        byte_d  = 1'b0;
        state_d = SEND;
      end
      SEND: begin
        if (tx_idle) begin
          if (byte_q != 1'(BYTES_PER_WORD - 1)) begin
            tx_load = 1'b1;
            tx_data = word_q[7:0];
            byte_d  = 1'b1;
          end else begin
            // Stop bit of the low byte finishes on this edge
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        addr_d = addr_q + 1'b1;
        rem_d  = rem_q - 1'b1;
        if (rem_q == (ADDR_W + 1)'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = READ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_dump_uart.sv
module tb_mem_dump_uart;

  localparam int DIV = 8;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [9:0]  BaseAddr;
  logic [10:0] Count;
  logic [9:0]  RamAddrB;
  logic [15:0] RamQB;
  logic        Tx;
  logic        Busy;
  logic        Done;

  always #5 Clk = ~Clk;

  mem_dump_uart #(.CLK_HZ(8), .BAUD(1), .ADDR_W(10), .DATA_W(16)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .BaseAddr (BaseAddr),
    .Count    (Count),
    .RamAddrB (RamAddrB),
    .RamQB    (RamQB),
    .Tx       (Tx),
    .Busy     (Busy),
    .Done     (Done)
  );

  // RAM image: high byte A5, low byte the address's low 8 bits (so 1022,1023,0 read A5FE, A5FF, A500)
  logic [15:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = {8'hA5, 8'(i)};
  always @(posedge Clk) RamQB <= mem[RamAddrB];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Line monitor sampled on the falling edge: a value seen here is what edge cyc+1 samples
  logic [7:0] rx_q[$];
  int         rx_start_q[$];
  int         done_q[$];
  int         frame_err = 0;
  int         busy_cnt = 0;
  bit         dec_active = 1'b0;
  int         dec_cnt = 0;
  int         dec_bit = 0;
  logic [7:0] dec_byte = 8'h00;

  always @(negedge Clk) begin
    if (Rst === 1'b1) begin
      dec_active = 1'b0;
    end else begin
      if (Done === 1'b1) done_q.push_back(cyc + 1);
      if (Busy === 1'b1) busy_cnt++;
      if (!dec_active) begin
        if (Tx === 1'b0) begin
          dec_active = 1'b1;
          dec_cnt = 1;
          rx_start_q.push_back(cyc + 1);
        end
      end else begin
        if (dec_cnt % DIV == DIV / 2) begin
          dec_bit = dec_cnt / DIV;
          if (dec_bit == 0) begin
            if (Tx !== 1'b0) frame_err++;
          end else if (dec_bit <= 8) begin
            dec_byte = {Tx, dec_byte[7:1]};
          end else begin
            if (Tx !== 1'b1) frame_err++;
            rx_q.push_back(dec_byte);
            dec_active = 1'b0;
          end
        end
        dec_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    rx_q.delete();
    rx_start_q.delete();
    done_q.delete();
    frame_err = 0;
    busy_cnt = 0;
  endtask

  // Drive Start for one cycle; n is the index of the edge that samples it
  task automatic start_dump(input logic [9:0] base, input logic [10:0] cnt, output int n);
    BaseAddr = base;
    Count = cnt;
    Start = 1'b1;
    tick();
    n = cyc;
    Start = 1'b0;
    BaseAddr = ~base;
    Count = ~cnt;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && done_q.size() == 0; i++) tick();
    check({name, "_done_seen"}, 32'(done_q.size() != 0), 1);
    ticks(4);
  endtask

  typedef struct {
    logic [9:0]  base;
    logic [10:0] count;
    int          done_dly;
    int          busy_cyc;
    logic [7:0]  first_lo;
    logic [7:0]  last_lo;
  } row_t;

  row_t rows[5];

  task automatic run_row(input string name, input row_t r);
    int n;
    int mism;
    int a;
    clear_mon();
    start_dump(r.base, r.count, n);
    wait_done(name, 163 * int'(r.count) + 50);
    check({name, "_done_delay"}, (done_q.size() > 0) ? 32'(done_q[0] - n) : 32'hFFFF_FFFF, 32'(r.done_dly));
    check({name, "_done_pulses"}, 32'(done_q.size()), 1);
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(r.busy_cyc));
    check({name, "_byte_count"}, 32'(rx_q.size()), 32'(2 * int'(r.count)));
    check({name, "_frame_err"}, 32'(frame_err), 0);
    mism = 0;
    for (int w = 0; w < int'(r.count); w++) begin
      a = (int'(r.base) + w) % 1024;
      if (2 * w + 1 < rx_q.size()) begin
        if (rx_q[2 * w] !== 8'hA5 || rx_q[2 * w + 1] !== 8'(a)) mism++;
      end else begin
        mism++;
      end
    end
    check({name, "_byte_mismatches"}, 32'(mism), 0);
    if (rx_q.size() >= 2) begin
      check({name, "_first_lo"}, 32'(rx_q[1]), 32'(r.first_lo));
      check({name, "_last_lo"}, 32'(rx_q[rx_q.size() - 1]), 32'(r.last_lo));
    end
    if (rx_start_q.size() >= 1 && r.count != 0)
      check({name, "_first_start_edge"}, 32'(rx_start_q[0] - n), 3);
    if (rx_start_q.size() >= 3)
      check({name, "_word_period"}, 32'(rx_start_q[2] - rx_start_q[0]), 163);
  endtask

  initial begin
    int n;
    int n2;
    int i;

    rows[0] = '{base: 10'd3,    count: 11'd1,  done_dly: 164,  busy_cyc: 163,  first_lo: 8'h03, last_lo: 8'h03};
    rows[1] = '{base: 10'd1022, count: 11'd3,  done_dly: 490,  busy_cyc: 489,  first_lo: 8'hFE, last_lo: 8'h00};
    rows[2] = '{base: 10'd5,    count: 11'd0,  done_dly: 1,    busy_cyc: 0,    first_lo: 8'h00, last_lo: 8'h00};
    rows[3] = '{base: 10'd128,  count: 11'd16, done_dly: 2609, busy_cyc: 2608, first_lo: 8'h80, last_lo: 8'h8F};
    rows[4] = '{base: 10'd600,  count: 11'd2,  done_dly: 327,  busy_cyc: 326,  first_lo: 8'h58, last_lo: 8'h59};

    // Reset with Start asserted: reset wins
    Rst = 1'b1;
    Start = 1'b1;
    BaseAddr = 10'd5;
    Count = 11'd1;
    ticks(3);
    check("reset_tx", 32'(Tx), 1);
    check("reset_busy", 32'(Busy), 0);
    check("reset_done", 32'(Done), 0);
    check("reset_addr", 32'(RamAddrB), 0);
    Start = 1'b0;
    Rst = 1'b0;
    tick();
    check("reset_start_ignored", 32'(Busy), 0);
    ticks(3);

    // Single word: exact edge timing of address, start bit and first data bit
    clear_mon();
    start_dump(10'd3, 11'd1, n);
    check("single_busy_n1", 32'(Busy), 1);
    check("single_addr_n1", 32'(RamAddrB), 3);
    check("single_tx_n1", 32'(Tx), 1);
    tick();
    check("single_tx_n2", 32'(Tx), 1);
    tick();
    check("single_tx_n3", 32'(Tx), 0);
    ticks(7);
    check("single_tx_n10", 32'(Tx), 0);
    tick();
    check("single_tx_n11", 32'(Tx), 1);
    wait_done("single", 250);
    check("single_done_delay", (done_q.size() > 0) ? 32'(done_q[0] - n) : 32'hFFFF_FFFF, 164);
    ticks(3);

    for (int r = 0; r < 5; r++) begin
      run_row($sformatf("row%0d", r), rows[r]);
      ticks(3);
    end

    // Second Start while busy is dropped
    clear_mon();
    start_dump(10'd3, 11'd1, n);
    ticks(49);
    BaseAddr = 10'd7;
    Count = 11'd1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_done("busy_start", 250);
    ticks(200);
    check("busy_start_bytes", 32'(rx_q.size()), 2);
    if (rx_q.size() >= 2) check("busy_start_lo", 32'(rx_q[1]), 8'h03);
    check("busy_start_done_pulses", 32'(done_q.size()), 1);

    // Start during the Done cycle is dropped
    clear_mon();
    start_dump(10'd3, 11'd1, n);
    for (i = 0; i < 300 && Done !== 1'b1; i++) tick();
    check("done_cycle_reached", 32'(Done), 1);
    BaseAddr = 10'd7;
    Count = 11'd1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("done_cycle_start_busy", 32'(Busy), 0);
    ticks(200);
    check("done_cycle_start_bytes", 32'(rx_q.size()), 2);

    // Reset mid-frame, then a fresh dump
    clear_mon();
    start_dump(10'd3, 11'd1, n);
    ticks(39);
    check("midreset_pre_tx", 32'(Tx), 0);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("midreset_tx", 32'(Tx), 1);
    check("midreset_busy", 32'(Busy), 0);
    check("midreset_addr", 32'(RamAddrB), 0);
    check("midreset_done", 32'(Done), 0);
    ticks(4);
    clear_mon();
    start_dump(10'd9, 11'd1, n2);
    check("midreset_restart_edge", 32'(n2 - n), 45);
    wait_done("midreset", 250);
    check("midreset_bytes", 32'(rx_q.size()), 2);
    if (rx_q.size() >= 2) begin
      check("midreset_hi", 32'(rx_q[0]), 8'hA5);
      check("midreset_lo", 32'(rx_q[1]), 8'h09);
    end
    check("midreset_frame_err", 32'(frame_err), 0);
    check("midreset_done_delay", (done_q.size() > 0) ? 32'(done_q[0] - n2) : 32'hFFFF_FFFF, 164);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
